// File: rtl/test_result_scoreboard.sv
// test_result_scoreboard: scores expected/measured compares, tallies results and decides a sticky PASS/FAIL verdict
module test_result_scoreboard #(
  parameter int DATA_WIDTH      = 32,
  parameter int NUMBER_OF_TESTS = 16,
  parameter int COUNT_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES  = 50000,
  parameter bit STOP_ON_FAIL    = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   cmp_valid,
  output logic                   cmp_ready,
  input  logic [DATA_WIDTH-1:0]  expected,
  input  logic [DATA_WIDTH-1:0]  measured,
  input  logic                   measured_bad,
  input  logic                   all_done,
  output logic                   result_valid,
  output logic                   result_pass,
  output logic [COUNT_WIDTH-1:0] test_count,
  output logic [COUNT_WIDTH-1:0] fail_count,
  output logic                   test_passed,
  output logic                   test_failed,
  output logic                   timeout
);
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, PASS, FAIL} state_t;
  localparam logic [COUNT_WIDTH-1:0] CMAX = '1;
  state_t state_q, state_d;
  logic [COUNT_WIDTH-1:0] test_count_q, test_count_d, fail_count_q, fail_count_d;
  logic [31:0] timer_q, timer_d;
  logic rv_q, rv_d, rp_q, rp_d, to_q, to_d;
  logic xfer, miss, stop, expire;
  // a scored miscompare blocks further transfers so nothing lands after the stop decision
  assign stop      = STOP_ON_FAIL && rv_q && !rp_q;
  assign expire    = (TIMEOUT_CYCLES != 0) && (timer_q == 32'(TIMEOUT_CYCLES - 1));
  assign cmp_ready = (state_q == RUN) && !stop;
  assign xfer      = cmp_valid && cmp_ready && !start;
  assign miss      = (expected != measured) || measured_bad;
  assign result_valid = rv_q;
  assign result_pass  = rp_q;
  assign test_count   = test_count_q;
  assign fail_count   = fail_count_q;
  assign test_passed  = state_q == PASS;
  assign test_failed  = state_q == FAIL;
  assign timeout      = to_q;
  // next-state, scoring and counter update; start overrides everything as a restart
  always_comb begin
    state_d      = state_q;
    timer_d      = (state_q == RUN) ? timer_q + 32'd1 : timer_q;
    rv_d         = xfer;
    rp_d         = !miss;
    to_d         = to_q;
    test_count_d = (xfer && test_count_q != CMAX) ? test_count_q + 1'b1 : test_count_q;
    fail_count_d = (xfer && miss && fail_count_q != CMAX) ? fail_count_q + 1'b1 : fail_count_q;
    case (state_q)
      RUN: begin
        state_d = (expire || stop) ? FAIL : all_done ? DRAIN : RUN;
        to_d    = to_q || expire;
      end
      DRAIN: state_d = (test_count_q == COUNT_WIDTH'(NUMBER_OF_TESTS) && fail_count_q == '0) ? PASS : FAIL;
      default: state_d = state_q;
    endcase
    if (start) begin
      state_d      = RUN;
      timer_d      = '0;
      rv_d         = 1'b0;
      to_d         = 1'b0;
      test_count_d = '0;
      fail_count_d = '0;
    end
  end
  // state and scoring registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      rv_q         <= 1'b0;
      rp_q         <= 1'b0;
      to_q         <= 1'b0;
      test_count_q <= '0;
      fail_count_q <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      rv_q         <= rv_d;
      rp_q         <= rp_d;
      to_q         <= to_d;
      test_count_q <= test_count_d;
      fail_count_q <= fail_count_d;
    end
  end
endmodule

// File: tb/tb_test_result_scoreboard.sv
// tb_test_result_scoreboard: scoreboard bench for default, short-timeout and stop-on-fail scoreboards
module tb_test_result_scoreboard;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, cmp_valid = 1'b0, measured_bad = 1'b0, all_done = 1'b0;
  logic [31:0] expected = '0, measured = '0;
  logic [2:0] ready, rv, rp, tp, tf, to;
  logic [15:0] tc[3], fc[3];
  logic sb[$];
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  test_result_scoreboard u_main (
    .clk(clk), .rst_n(rst_n), .start(start), .cmp_valid(cmp_valid), .cmp_ready(ready[0]),
    .expected(expected), .measured(measured), .measured_bad(measured_bad), .all_done(all_done),
    .result_valid(rv[0]), .result_pass(rp[0]), .test_count(tc[0]), .fail_count(fc[0]),
    .test_passed(tp[0]), .test_failed(tf[0]), .timeout(to[0]));
  test_result_scoreboard #(.TIMEOUT_CYCLES(100)) u_tmo (
    .clk(clk), .rst_n(rst_n), .start(start), .cmp_valid(cmp_valid), .cmp_ready(ready[1]),
    .expected(expected), .measured(measured), .measured_bad(measured_bad), .all_done(all_done),
    .result_valid(rv[1]), .result_pass(rp[1]), .test_count(tc[1]), .fail_count(fc[1]),
    .test_passed(tp[1]), .test_failed(tf[1]), .timeout(to[1]));
  test_result_scoreboard #(.STOP_ON_FAIL(1'b1)) u_stop (
    .clk(clk), .rst_n(rst_n), .start(start), .cmp_valid(cmp_valid), .cmp_ready(ready[2]),
    .expected(expected), .measured(measured), .measured_bad(measured_bad), .all_done(all_done),
    .result_valid(rv[2]), .result_pass(rp[2]), .test_count(tc[2]), .fail_count(fc[2]),
    .test_passed(tp[2]), .test_failed(tf[2]), .timeout(to[2]));

  // every result the main scoreboard produces is matched against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && rv[0]) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got result_valid=1 with pass=%0b, required no result", rp[0]);
      end else if (rp[0] !== sb[0]) begin
        errors++;
        $display("FAIL result_pass: got %0b required %0b", rp[0], sb[0]);
        void'(sb.pop_front());
      end else void'(sb.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] e, input logic [31:0] m, input logic b);
    cmp_valid = 1'b1;
    expected = e;
    measured = m;
    measured_bad = b;
    @(negedge clk);
    if (ready[0] && !start) sb.push_back((e == m) && !b);
    step();
  endtask

  task automatic test_reset();
    repeat (2) step();
    checks++;
    if ({ready[0], rv[0], rp[0], tp[0], tf[0], to[0]} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 000000", {ready[0], rv[0], rp[0], tp[0], tf[0], to[0]});
    end
    checks++;
    if ({tc[0], fc[0]} !== 32'b0) begin
      errors++;
      $display("FAIL reset_counts: got tc=%0d fc=%0d required 0 0", tc[0], fc[0]);
    end
    rst_n = 1'b1;
    all_done = 1'b1;
    cmp_valid = 1'b1;
    step();
    all_done = 1'b0;
    cmp_valid = 1'b0;
    step();
    checks++;
    if ({tp, tf, rv, ready} !== 12'b0) begin
      errors++;
      $display("FAIL idle_ignores: got %b required all 0", {tp, tf, rv, ready});
    end
  endtask

  task automatic test_all_pass();
    pulse_start();
    for (int i = 0; i < 16; i++) send(32'(i * 3 + 1), 32'(i * 3 + 1), 1'b0);
    cmp_valid = 1'b0;
    all_done = 1'b1;
    step();
    all_done = 1'b0;
    step();
    checks++;
    if (tc[0] !== 16'd16 || fc[0] !== 16'd0) begin
      errors++;
      $display("FAIL pass_counts: got tc=%0d fc=%0d required 16 0", tc[0], fc[0]);
    end
    checks++;
    if ({tp[0], tf[0], to[0]} !== 3'b100) begin
      errors++;
      $display("FAIL pass_verdict: got passed/failed/timeout=%b required 100", {tp[0], tf[0], to[0]});
    end
  endtask

  task automatic test_miscompare();
    pulse_start();
    for (int i = 0; i < 16; i++)
      if (i == 4) send(32'h0000_00A5, 32'h0000_00A4, 1'b0);
      else send(32'(i), 32'(i), 1'b0);
    cmp_valid = 1'b0;
    all_done = 1'b1;
    step();
    all_done = 1'b0;
    step();
    checks++;
    if (tc[0] !== 16'd16 || fc[0] !== 16'd1) begin
      errors++;
      $display("FAIL mis_counts: got tc=%0d fc=%0d required 16 1", tc[0], fc[0]);
    end
    checks++;
    if ({tp[0], tf[0]} !== 2'b01) begin
      errors++;
      $display("FAIL mis_verdict: got passed/failed=%b required 01", {tp[0], tf[0]});
    end
  endtask

  task automatic test_short_count();
    pulse_start();
    for (int i = 0; i < 15; i++) begin
      all_done = (i == 14);
      send(32'(i + 100), 32'(i + 100), 1'b0);
    end
    all_done = 1'b0;
    cmp_valid = 1'b0;
    step();
    checks++;
    if (tc[0] !== 16'd15 || fc[0] !== 16'd0) begin
      errors++;
      $display("FAIL short_counts: got tc=%0d fc=%0d required 15 0", tc[0], fc[0]);
    end
    checks++;
    if ({tp[0], tf[0], to[0]} !== 3'b010) begin
      errors++;
      $display("FAIL short_verdict: got passed/failed/timeout=%b required 010", {tp[0], tf[0], to[0]});
    end
  endtask

  task automatic test_bad_measure();
    pulse_start();
    send(32'h1234, 32'h1234, 1'b1);
    cmp_valid = 1'b0;
    measured_bad = 1'b0;
    step();
    checks++;
    if (fc[0] !== 16'd1 || tc[0] !== 16'd1) begin
      errors++;
      $display("FAIL bad_counts: got tc=%0d fc=%0d required 1 1", tc[0], fc[0]);
    end
  endtask

  task automatic test_timeout();
    pulse_start();
    repeat (99) step();
    checks++;
    if ({tf[1], to[1], ready[1]} !== 3'b001) begin
      errors++;
      $display("FAIL tmo_early: got failed/timeout/ready=%b required 001 after 99 cycles", {tf[1], to[1], ready[1]});
    end
    step();
    checks++;
    if ({tp[1], tf[1], to[1], ready[1]} !== 4'b0110) begin
      errors++;
      $display("FAIL tmo_expire: got passed/failed/timeout/ready=%b required 0110", {tp[1], tf[1], to[1], ready[1]});
    end
    pulse_start();
    repeat (99) step();
    all_done = 1'b1;
    step();
    all_done = 1'b0;
    checks++;
    if ({tp[1], tf[1], to[1]} !== 3'b011) begin
      errors++;
      $display("FAIL tmo_vs_done: got passed/failed/timeout=%b required 011", {tp[1], tf[1], to[1]});
    end
    step();
  endtask

  task automatic test_stop_on_fail();
    pulse_start();
    send(32'd1, 32'd1, 1'b0);
    send(32'd2, 32'd2, 1'b0);
    send(32'd3, 32'd4, 1'b0);
    checks++;
    if ({rv[2], rp[2], ready[2], tf[2]} !== 4'b1000) begin
      errors++;
      $display("FAIL stop_result3: got valid/pass/ready/failed=%b required 1000", {rv[2], rp[2], ready[2], tf[2]});
    end
    send(32'd4, 32'd4, 1'b0);
    checks++;
    if (tf[2] !== 1'b1 || tc[2] !== 16'd3) begin
      errors++;
      $display("FAIL stop_fail: got failed=%0b tc=%0d required 1 3", tf[2], tc[2]);
    end
    send(32'd5, 32'd5, 1'b0);
    send(32'd6, 32'd6, 1'b0);
    cmp_valid = 1'b0;
    checks++;
    if (tc[2] !== 16'd3 || fc[2] !== 16'd1 || ready[2] !== 1'b0 || tp[2] !== 1'b0) begin
      errors++;
      $display("FAIL stop_hold: got tc=%0d fc=%0d ready=%0b passed=%0b required 3 1 0 0", tc[2], fc[2], ready[2], tp[2]);
    end
    all_done = 1'b1;
    step();
    all_done = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    pulse_start();
    send(32'd7, 32'd7, 1'b0);
    send(32'd8, 32'd8, 1'b0);
    cmp_valid = 1'b1;
    expected = 32'd9;
    measured = 32'd8;
    start = 1'b1;
    step();
    start = 1'b0;
    cmp_valid = 1'b0;
    checks++;
    if ({rv[0], ready[0], tp[0], tf[0]} !== 4'b0100 || tc[0] !== 16'd0 || fc[0] !== 16'd0) begin
      errors++;
      $display("FAIL restart: got valid/ready/passed/failed=%b tc=%0d fc=%0d required 0100 0 0", {rv[0], ready[0], tp[0], tf[0]}, tc[0], fc[0]);
    end
    for (int i = 0; i < 16; i++) begin
      all_done = (i == 15);
      send(32'hF000 + 32'(i), 32'hF000 + 32'(i), 1'b0);
    end
    all_done = 1'b0;
    cmp_valid = 1'b0;
    step();
    checks++;
    if ({tp[0], tf[0]} !== 2'b10 || tc[0] !== 16'd16) begin
      errors++;
      $display("FAIL b2b_verdict: got passed/failed=%b tc=%0d required 10 16", {tp[0], tf[0]}, tc[0]);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d outstanding results required 0", sb.size());
    end
  endtask

  task automatic test_mid_reset();
    pulse_start();
    for (int i = 0; i < 3; i++) send(32'(i), 32'(i + 1), 1'b0);
    cmp_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ready, rv, rp, tp, tf, to} !== 18'b0 || {tc[0], fc[0], tc[2], fc[2]} !== 64'b0) begin
      errors++;
      $display("FAIL async_reset: got flags=%b tc=%0d fc=%0d required all 0", {ready, rv, rp, tp, tf, to}, tc[0], fc[0]);
    end
    sb.delete();
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if ({ready[0], tp[0], tf[0]} !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle: got ready/passed/failed=%b required 000", {ready[0], tp[0], tf[0]});
    end
  endtask

  initial begin
    test_reset();
    test_all_pass();
    test_miscompare();
    test_short_count();
    test_bad_measure();
    test_timeout();
    test_stop_on_fail();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
